// File: rtl/btm4_multiplier.sv
// Balanced-ternary multiplier tile: 2-trit X times 2-trit Y gives a 4-trit
// product, registered once on clk (one-cycle latency).
// Trit code: 2'b01 = -1, 2'b11 = 0, 2'b10 = +1, 2'b00 = illegal.
// Ports:
//   clk     - single clock, rising edge
//   rst     - synchronous active-high reset, loads io_out = 8'hFF (product 0)
//   io_in   - [7:6]=x1 (MST of X), [5:4]=x0, [3:2]=y1 (MST of Y), [1:0]=y0
//   io_out  - [7:6]=z3 (MST), [5:4]=z2, [3:2]=z1, [1:0]=z0; 8'h00 flags illegal input
module btm4_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int unsigned VW      = 7;   // signed working width for operands/product
  localparam int unsigned NTRITS  = 4;   // product trits
  localparam logic [7:0]  OUT_RST = 8'hFF;
  localparam logic [7:0]  OUT_ERR = 8'h00;

  // Decode one trit code to a signed value; illegal code decodes to 0 and
  // is caught separately by legal_c.
  function automatic logic signed [VW-1:0] trit_val(input logic [1:0] code);
    logic signed [VW-1:0] v;
    case (code)
      2'b01:   v = -7'sd1;
      2'b10:   v = 7'sd1;
      default: v = 7'sd0;
    endcase
    return v;
  endfunction

  // Encode an offset digit (0,1,2 meaning -1,0,+1) back to a trit code.
  function automatic logic [1:0] trit_enc(input logic [1:0] dig);
    logic [1:0] code;
    case (dig)
      2'd0:    code = 2'b01;
      2'd1:    code = 2'b11;
      2'd2:    code = 2'b10;
      default: code = 2'b00;
    endcase
    return code;
  endfunction

  logic                 legal_c;
  logic signed [VW-1:0] x_val_c;
  logic signed [VW-1:0] y_val_c;
  logic signed [VW-1:0] prod_c;
  logic        [VW-1:0] rem_c;
  logic        [1:0]    dig_c;
  logic        [7:0]    z_c;

  // Decode, multiply, convert to balanced ternary.
  // Adding 40 (= 1111 in balanced ternary) makes the product non-negative, so
  // plain divide-by-3 digits d in {0,1,2} map directly to trits d-1; this is
  // the same as the remainder-2 -> -1 with carry correction, done up front.
  always_comb begin
    legal_c = (io_in[7:6] != 2'b00) && (io_in[5:4] != 2'b00) &&
              (io_in[3:2] != 2'b00) && (io_in[1:0] != 2'b00);
    x_val_c = trit_val(io_in[7:6]) * 7'sd3 + trit_val(io_in[5:4]);
    y_val_c = trit_val(io_in[3:2]) * 7'sd3 + trit_val(io_in[1:0]);
    prod_c  = x_val_c * y_val_c;
    rem_c   = VW'(prod_c + 7'sd40);
    dig_c   = 2'd0;
    z_c     = 8'h00;
    for (int i = 0; i < NTRITS; i++) begin
      dig_c         = 2'(rem_c % 7'd3);
      rem_c         = rem_c / 7'd3;
      z_c[2*i +: 2] = trit_enc(dig_c);
    end
  end

  // Output register: reset wins, then illegal-input flag, then product.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_out <= OUT_RST;
    end else if (!legal_c) begin
      io_out <= OUT_ERR;
    end else begin
      io_out <= z_c;
    end
  end

endmodule

// File: tb/tb_btm4_multiplier.sv
// Self-checking bench for btm4_multiplier: integer reference model with a
// brute-force balanced-ternary search, per-cycle scoreboard plus literal pins.
module tb_btm4_multiplier;

  logic       clk;
  logic       rst;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int checks   = 0;
  int failures = 0;

  btm4_multiplier dut (
    .clk    (clk),
    .rst    (rst),
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tval(input logic [1:0] c);
    case (c)
      2'b01:   return -1;
      2'b11:   return 0;
      2'b10:   return 1;
      default: return 99;
    endcase
  endfunction

  function automatic logic [1:0] tenc(input int v);
    case (v)
      -1:      return 2'b01;
      0:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Expected io_out for a sample of io_in (no reset).
  function automatic logic [7:0] model(input logic [7:0] in);
    int x, y, p;
    if (in[7:6] == 2'b00 || in[5:4] == 2'b00 || in[3:2] == 2'b00 || in[1:0] == 2'b00)
      return 8'h00;
    x = 3 * tval(in[7:6]) + tval(in[5:4]);
    y = 3 * tval(in[3:2]) + tval(in[1:0]);
    p = x * y;
    for (int a = -1; a <= 1; a++)
      for (int b = -1; b <= 1; b++)
        for (int c = -1; c <= 1; c++)
          for (int d = -1; d <= 1; d++)
            if (27*a + 9*b + 3*c + d == p)
              return {tenc(a), tenc(b), tenc(c), tenc(d)};
    return 8'h5A;
  endfunction

  // Per-cycle scoreboard: expectation formed at the same edge the DUT samples.
  logic [7:0] exp_q;
  logic       exp_valid = 1'b0;

  always @(posedge clk) begin
    exp_q     <= rst ? 8'hFF : model(io_in);
    exp_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (io_out !== exp_q) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t io_out=%h expected=%h", $time, io_out, exp_q);
      end
    end
  end

  task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one sample, then check the registered output against a literal.
  task automatic step(input string name, input logic r, input logic [7:0] in,
                      input logic [7:0] req);
    @(negedge clk);
    rst   = r;
    io_in = in;
    @(posedge clk);
    #1;
    check_lit(name, io_out, req);
  endtask

  typedef struct {
    logic [7:0] in;
    logic [7:0] out;
  } vec_t;

  vec_t vecs [10] = '{
    '{8'h55, 8'h96}, '{8'h79, 8'hDB}, '{8'h97, 8'hDB}, '{8'h6B, 8'hDB},
    '{8'hB6, 8'hDB}, '{8'hA5, 8'h69}, '{8'h57, 8'hEB}, '{8'h56, 8'hED},
    '{8'h76, 8'hE7}, '{8'h7F, 8'hFF}
  };

  logic [1:0] codes [3] = '{2'b01, 2'b11, 2'b10};

  initial begin
    rst   = 1'b1;
    io_in = 8'h55;

    // Pin the model itself against hand-computed values.
    foreach (vecs[i]) check_lit("model_pin", model(vecs[i].in), vecs[i].out);
    check_lit("model_illegal", model(8'h15), 8'h00);

    // Reset held two cycles with a live operand on the pins.
    step("reset_1", 1'b1, 8'h55, 8'hFF);
    step("reset_2", 1'b1, 8'h55, 8'hFF);
    step("reset_release", 1'b0, 8'h55, 8'h96);

    foreach (vecs[i]) step("directed", 1'b0, vecs[i].in, vecs[i].out);

    step("illegal", 1'b0, 8'h15, 8'h00);
    step("illegal_recover", 1'b0, 8'hFF, 8'hFF);
    step("reset_override", 1'b1, 8'hA5, 8'hFF);
    step("reset_override_illegal", 1'b1, 8'h00, 8'hFF);
    step("after_reset", 1'b0, 8'hA5, 8'h69);

    // Exhaustive legal pairs, back to back.
    for (int a = 0; a < 3; a++)
      for (int b = 0; b < 3; b++)
        for (int c = 0; c < 3; c++)
          for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            rst   = 1'b0;
            io_in = {codes[a], codes[b], codes[c], codes[d]};
          end

    // Random traffic: mostly legal, some raw bytes, occasional reset.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] v;
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        v = 8'($urandom);
      end else begin
        v = {codes[$urandom_range(0, 2)], codes[$urandom_range(0, 2)],
             codes[$urandom_range(0, 2)], codes[$urandom_range(0, 2)]};
      end
      io_in = v;
      rst   = ($urandom_range(0, 19) == 0);
    end

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
